// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor redirect controller.
//   wp_e    : EX-stage misprediction verdict codes
//   meta_t  : per-instruction prediction metadata carried IF -> EX
//   state_e : redirect FSM states
package bp_pkg;

    typedef enum logic [1:0] {
        WP_OK        = 2'b00,
        WP_NOT_TAKEN = 2'b01,
        WP_TAKEN     = 2'b10
    } wp_e;

    typedef struct packed {
        logic valid;
        logic hit;
    } meta_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

    localparam meta_t META_BUBBLE = '{valid: 1'b0, hit: 1'b0};

    // Upper verdict bit selects the resolved ALU target; 2'b11 therefore
    // behaves exactly like WP_TAKEN.
    function automatic logic wp_use_alu_target(input logic [1:0] wp);
        return wp[1];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk_i   : clock
//   clear_i : synchronous clear to zero (highest priority)
//   inc_i   : increment request; ignored once the count is all-ones
//   cnt_o   : registered count value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(32'd1);

    logic [W-1:0] cnt_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            cnt_r <= {W{1'b0}};
        end else if (inc_i && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/bp_redirect_ctrl.sv
// Consumer end of the branch-predictor interface.
// Chooses the next PC from the IF-stage prediction and the EX-stage verdict,
// squashes IF/ID and ID/EX on a misprediction, pipes {valid, hit} from IF to
// EX so the predictor sees the right hit_ex, and counts resolved control
// transfers and mispredictions.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   pc_i, hit_i, predicted_pc_i : IF PC and BTB lookup result
//   wrong_predicted_i, alu_pc_i, pc_ex_i, is_ctrl_ex_i : EX resolution
//   stall_i                     : hazard stall (hold PC/IF-ID, bubble ID/EX)
//   next_pc_o, pc_we_o          : PC register input and write enable
//   flush_ifid_o, flush_idex_o, redirect_o : redirect controls
//   hit_ex_o, valid_ex_o        : ID/EX metadata register
//   br_cnt_o, mis_cnt_o         : saturating performance counters
module bp_redirect_ctrl
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32,
    parameter int RECOVER_CYC = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             hit_i,
    input  logic [XLEN-1:0]  predicted_pc_i,
    input  logic [1:0]       wrong_predicted_i,
    input  logic [XLEN-1:0]  alu_pc_i,
    input  logic [XLEN-1:0]  pc_ex_i,
    input  logic             is_ctrl_ex_i,
    input  logic             stall_i,
    output logic [XLEN-1:0]  next_pc_o,
    output logic             pc_we_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic             hit_ex_o,
    output logic             valid_ex_o,
    output logic             redirect_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o
);

    localparam int              RC_W        = (RECOVER_CYC > 2) ? $clog2(RECOVER_CYC) : 1;
    localparam logic            HAS_RECOVER = (RECOVER_CYC > 0) ? 1'b1 : 1'b0;
    localparam logic [RC_W-1:0] RC_ZERO     = {RC_W{1'b0}};
    localparam logic [RC_W-1:0] RC_ONE      = RC_W'(32'd1);
    localparam logic [RC_W-1:0] RC_LOAD     = (RECOVER_CYC > 0) ? RC_W'(RECOVER_CYC - 1) : RC_ZERO;
    localparam logic [XLEN-1:0] PC_STEP     = XLEN'(32'd4);

    meta_t           ifid_r, ifid_nxt_s;
    meta_t           idex_r, idex_nxt_s;
    state_e          state_r, state_nxt_s;
    logic [RC_W-1:0] rcnt_r, rcnt_nxt_s;
    logic            mis_s;
    logic            br_inc_s;
    logic [XLEN-1:0] next_pc_s;

    // Qualified verdict: only a real EX instruction outside the refill window
    // may redirect; reset masks it so the outputs are quiet during reset.
    always_comb begin
        mis_s    = 1'b0;
        br_inc_s = 1'b0;
        if (!rst_i && (state_r == RUN) && idex_r.valid) begin
            mis_s    = (wrong_predicted_i != WP_OK);
            br_inc_s = is_ctrl_ex_i;
        end else begin
            mis_s    = 1'b0;
            br_inc_s = 1'b0;
        end
    end

    // Next-PC selection: EX redirect beats IF prediction beats sequential.
    always_comb begin
        next_pc_s = pc_i + PC_STEP;
        if (rst_i) begin
            next_pc_s = {XLEN{1'b0}};
        end else if (mis_s && wp_use_alu_target(wrong_predicted_i)) begin
            next_pc_s = alu_pc_i;
        end else if (mis_s) begin
            next_pc_s = pc_ex_i + PC_STEP;
        end else if (hit_i) begin
            next_pc_s = predicted_pc_i;
        end else begin
            next_pc_s = pc_i + PC_STEP;
        end
    end

    // Metadata pipe next values; a flush wins over a stall.
    always_comb begin
        ifid_nxt_s = ifid_r;
        idex_nxt_s = idex_r;
        if (mis_s) begin
            ifid_nxt_s = META_BUBBLE;
            idex_nxt_s = META_BUBBLE;
        end else if (stall_i) begin
            ifid_nxt_s = ifid_r;
            idex_nxt_s = META_BUBBLE;
        end else begin
            ifid_nxt_s = '{valid: 1'b1, hit: hit_i};
            idex_nxt_s = ifid_r;
        end
    end

    // Redirect FSM next state: the refill window is time-based, so stalls
    // do not extend it.
    always_comb begin
        state_nxt_s = state_r;
        rcnt_nxt_s  = rcnt_r;
        case (state_r)
            RUN: begin
                if (mis_s && HAS_RECOVER) begin
                    state_nxt_s = RECOVER;
                    rcnt_nxt_s  = RC_LOAD;
                end else begin
                    state_nxt_s = RUN;
                    rcnt_nxt_s  = rcnt_r;
                end
            end
            RECOVER: begin
                if (rcnt_r == RC_ZERO) begin
                    state_nxt_s = RUN;
                    rcnt_nxt_s  = RC_ZERO;
                end else begin
                    state_nxt_s = RECOVER;
                    rcnt_nxt_s  = rcnt_r - RC_ONE;
                end
            end
            default: begin
                state_nxt_s = RUN;
                rcnt_nxt_s  = RC_ZERO;
            end
        endcase
    end

    // Pipeline metadata and FSM registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ifid_r  <= META_BUBBLE;
            idex_r  <= META_BUBBLE;
            state_r <= RUN;
            rcnt_r  <= RC_ZERO;
        end else begin
            ifid_r  <= ifid_nxt_s;
            idex_r  <= idex_nxt_s;
            state_r <= state_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (br_inc_s),
        .cnt_o   (br_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_mis_cnt (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (mis_s),
        .cnt_o   (mis_cnt_o)
    );

    assign next_pc_o    = next_pc_s;
    assign pc_we_o      = rst_i | mis_s | ~stall_i;
    assign flush_ifid_o = mis_s;
    assign flush_idex_o = mis_s;
    assign redirect_o   = mis_s;
    assign hit_ex_o     = idex_r.hit;
    assign valid_ex_o   = idex_r.valid;

endmodule

// File: tb/tb_bp_redirect_ctrl.sv
// Self-checking bench for bp_redirect_ctrl (XLEN=32, CNT_W=4, RECOVER_CYC=2).
// A per-cycle vector table drives inputs at the falling edge and checks the
// outputs 1 ns later; hand-written sequences cover counter saturation and
// reset in the middle of the refill window.
module tb_bp_redirect_ctrl;
    import bp_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int NVEC  = 20;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        hit;
        logic [31:0] ppc;
        logic [1:0]  wrong;
        logic [31:0] alu;
        logic [31:0] pcex;
        logic        ctrl;
        logic        stall;
        logic        chk_regs;
        logic [31:0] e_npc;
        logic        e_we;
        logic        e_fl;
        logic        e_hex;
        logic        e_vex;
        logic [3:0]  e_br;
        logic [3:0]  e_mis;
    } vec_t;

    logic             clk;
    logic             rst_i;
    logic [XLEN-1:0]  pc_i;
    logic             hit_i;
    logic [XLEN-1:0]  predicted_pc_i;
    logic [1:0]       wrong_predicted_i;
    logic [XLEN-1:0]  alu_pc_i;
    logic [XLEN-1:0]  pc_ex_i;
    logic             is_ctrl_ex_i;
    logic             stall_i;
    logic [XLEN-1:0]  next_pc_o;
    logic             pc_we_o;
    logic             flush_ifid_o;
    logic             flush_idex_o;
    logic             hit_ex_o;
    logic             valid_ex_o;
    logic             redirect_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] mis_cnt_o;

    int   n_pass;
    int   n_total;
    vec_t vecs [NVEC];

    bp_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .RECOVER_CYC(2)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .pc_i              (pc_i),
        .hit_i             (hit_i),
        .predicted_pc_i    (predicted_pc_i),
        .wrong_predicted_i (wrong_predicted_i),
        .alu_pc_i          (alu_pc_i),
        .pc_ex_i           (pc_ex_i),
        .is_ctrl_ex_i      (is_ctrl_ex_i),
        .stall_i           (stall_i),
        .next_pc_o         (next_pc_o),
        .pc_we_o           (pc_we_o),
        .flush_ifid_o      (flush_ifid_o),
        .flush_idex_o      (flush_idex_o),
        .hit_ex_o          (hit_ex_o),
        .valid_ex_o        (valid_ex_o),
        .redirect_o        (redirect_o),
        .br_cnt_o          (br_cnt_o),
        .mis_cnt_o         (mis_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input logic rst, input logic [31:0] pc, input logic hit,
                                input logic [31:0] ppc, input logic [1:0] wrong,
                                input logic [31:0] alu, input logic [31:0] pcex,
                                input logic ctrl, input logic stall, input logic chk,
                                input logic [31:0] npc, input logic we, input logic fl,
                                input logic hex, input logic vex,
                                input logic [3:0] br, input logic [3:0] mis);
        vec_t v;
        v.rst = rst; v.pc = pc; v.hit = hit; v.ppc = ppc; v.wrong = wrong;
        v.alu = alu; v.pcex = pcex; v.ctrl = ctrl; v.stall = stall; v.chk_regs = chk;
        v.e_npc = npc; v.e_we = we; v.e_fl = fl; v.e_hex = hex; v.e_vex = vex;
        v.e_br = br; v.e_mis = mis;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_i             = v.rst;
        pc_i              = v.pc;
        hit_i             = v.hit;
        predicted_pc_i    = v.ppc;
        wrong_predicted_i = v.wrong;
        alu_pc_i          = v.alu;
        pc_ex_i           = v.pcex;
        is_ctrl_ex_i      = v.ctrl;
        stall_i           = v.stall;
    endtask

    initial begin
        bit found;
        n_pass  = 0;
        n_total = 0;
        //             rst pc            hit ppc         wr     alu         pcex       ctl st    chk npc           we fl hex vex br    mis
        vecs[0]  = mk(1'b1, 32'h100,      1'b0, 32'h0,   2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        vecs[1]  = mk(1'b1, 32'h100,      1'b0, 32'h0,   2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        vecs[2]  = mk(1'b0, 32'h100,      1'b0, 32'h0,   2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h104,      1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        vecs[3]  = mk(1'b0, 32'h104,      1'b1, 32'h200, 2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        vecs[4]  = mk(1'b0, 32'h200,      1'b0, 32'h0,   2'b00, 32'h0,    32'h0,  1'b1, 1'b0, 1'b1, 32'h204,      1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        vecs[5]  = mk(1'b0, 32'h204,      1'b0, 32'h0,   2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h208,      1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0);
        vecs[6]  = mk(1'b0, 32'h208,      1'b0, 32'h0,   2'b10, 32'h340,  32'h0,  1'b1, 1'b0, 1'b1, 32'h340,      1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0);
        vecs[7]  = mk(1'b0, 32'h340,      1'b0, 32'h0,   2'b10, 32'h0,    32'h0,  1'b1, 1'b0, 1'b1, 32'h344,      1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1);
        vecs[8]  = mk(1'b0, 32'h344,      1'b0, 32'h0,   2'b10, 32'h0,    32'h0,  1'b1, 1'b0, 1'b1, 32'h348,      1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1);
        vecs[9]  = mk(1'b0, 32'h348,      1'b1, 32'h999, 2'b01, 32'h0,    32'h7C, 1'b0, 1'b1, 1'b1, 32'h80,       1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'd1);
        vecs[10] = mk(1'b0, 32'h80,       1'b0, 32'h0,   2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h84,       1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);
        vecs[11] = mk(1'b0, 32'h84,       1'b1, 32'h400, 2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h400,      1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);
        vecs[12] = mk(1'b0, 32'h400,      1'b1, 32'h500, 2'b00, 32'h0,    32'h0,  1'b0, 1'b1, 1'b1, 32'h500,      1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd2);
        vecs[13] = mk(1'b0, 32'h400,      1'b1, 32'h500, 2'b10, 32'h0,    32'h0,  1'b1, 1'b1, 1'b1, 32'h500,      1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);
        vecs[14] = mk(1'b0, 32'h400,      1'b1, 32'h500, 2'b10, 32'h0,    32'h0,  1'b1, 1'b1, 1'b1, 32'h500,      1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);
        vecs[15] = mk(1'b0, 32'h400,      1'b0, 32'h0,   2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h404,      1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);
        vecs[16] = mk(1'b0, 32'h404,      1'b0, 32'h0,   2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h408,      1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 4'd2);
        vecs[17] = mk(1'b0, 32'hFFFFFFFC, 1'b0, 32'h0,   2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd2);
        vecs[18] = mk(1'b0, 32'h0,        1'b0, 32'h0,   2'b11, 32'h1234, 32'h0,  1'b0, 1'b0, 1'b1, 32'h1234,     1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'd2);
        vecs[19] = mk(1'b0, 32'h1234,     1'b0, 32'h0,   2'b00, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h1238,     1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("r%0d_next_pc", i), next_pc_o, vecs[i].e_npc);
            check($sformatf("r%0d_pc_we", i), {31'd0, pc_we_o}, {31'd0, vecs[i].e_we});
            check($sformatf("r%0d_flush_ifid", i), {31'd0, flush_ifid_o}, {31'd0, vecs[i].e_fl});
            check($sformatf("r%0d_flush_idex", i), {31'd0, flush_idex_o}, {31'd0, vecs[i].e_fl});
            check($sformatf("r%0d_redirect", i), {31'd0, redirect_o}, {31'd0, vecs[i].e_fl});
            if (vecs[i].chk_regs) begin
                check($sformatf("r%0d_hit_ex", i), {31'd0, hit_ex_o}, {31'd0, vecs[i].e_hex});
                check($sformatf("r%0d_valid_ex", i), {31'd0, valid_ex_o}, {31'd0, vecs[i].e_vex});
                check($sformatf("r%0d_br_cnt", i), {28'd0, br_cnt_o}, {28'd0, vecs[i].e_br});
                check($sformatf("r%0d_mis_cnt", i), {28'd0, mis_cnt_o}, {28'd0, vecs[i].e_mis});
            end
        end

        // Repeated mispredictions: one redirect every three cycles until the
        // 4-bit counter pins at 15.
        @(negedge clk);
        rst_i = 1'b0; pc_i = 32'h1000; hit_i = 1'b0; predicted_pc_i = 32'h0;
        wrong_predicted_i = 2'b10; alu_pc_i = 32'h2000; pc_ex_i = 32'h0;
        is_ctrl_ex_i = 1'b0; stall_i = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        check("sat_mis_cnt_full", {28'd0, mis_cnt_o}, 32'hF);

        // One more mispredict after saturation.
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            if (redirect_o) found = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        check("sat_redirect_seen", {31'd0, found}, 32'd1);
        check("sat_redirect_target", next_pc_o, 32'h2000);
        @(posedge clk);
        #1;
        check("sat_mis_cnt_hold", {28'd0, mis_cnt_o}, 32'hF);
        check("sat_br_cnt", {28'd0, br_cnt_o}, 32'd2);
        check("recover_state", {31'd0, dut.state_r}, {31'd0, RECOVER});

        // Reset in the middle of the refill window.
        rst_i = 1'b1;
        #1;
        check("rst_next_pc", next_pc_o, 32'h0);
        check("rst_pc_we", {31'd0, pc_we_o}, 32'd1);
        check("rst_redirect", {31'd0, redirect_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("rst_state_run", {31'd0, dut.state_r}, {31'd0, RUN});
        check("rst_mis_cnt", {28'd0, mis_cnt_o}, 32'd0);
        check("rst_br_cnt", {28'd0, br_cnt_o}, 32'd0);
        check("rst_valid_ex", {31'd0, valid_ex_o}, 32'd0);
        check("rst_hit_ex", {31'd0, hit_ex_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
